thermal_guard: RTL and testbench
================================

Name: thermal_guard

Overview:
- Produces the `cpu_overheated` and `shut_off_computer` control signals that downstream latch-free control logic consumes.
- Input is a stream of sampled CPU temperature values with a valid strobe.
- Applies consecutive-sample debounce and hysteresis thresholds, then a cooldown hold.
- All outputs are registered, with no combinational latch paths.

Parameters:
- TEMP_W, 8, width of the temperature sample, unsigned.
- HOT_THRESH, 90, a sample >= this value is "hot".
- COOL_THRESH, 70, a sample < this value is "cool". Must be <= HOT_THRESH.
- DEBOUNCE, 3, number of consecutive qualifying valid samples needed to change state. Must be >= 1.
- COOLDOWN_CYC, 16, clock cycles that shut-off is held after cooling is confirmed. Must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- temp_valid  in  1  temp_data is a sample this cycle.
- temp_data  in  TEMP_W  unsigned temperature sample.
- cpu_overheated  out  1  registered overheat flag.
- shut_off_computer  out  1  registered shutdown request.
- trip_count  out  8  number of entries into OVERHEAT, saturates at 255.

Behaviour:
- Reset (synchronous, active-high, sampled on clk rise):
  - Outputs: cpu_overheated=0, shut_off_computer=0, trip_count=0.
  - Internal: state=NORMAL, hot_cnt=0, cool_cnt=0, timer=0.
  - Reset asserted mid-operation (any state) returns to these values on the next edge.
- Cycles with temp_valid=0 change no counter, except timer in COOLDOWN.
- Comparisons are unsigned, full TEMP_W width.
- Counters hot_cnt/cool_cnt are wide enough to hold DEBOUNCE; timer is wide enough to hold COOLDOWN_CYC.
- State NORMAL (both outputs 0):
  - Valid hot sample: hot_cnt+1.
  - Valid non-hot sample: hot_cnt cleared.
  - When the accepted sample makes hot_cnt==DEBOUNCE: next state OVERHEAT, hot_cnt cleared, trip_count+1 (saturating).
  - cpu_overheated=1 and shut_off_computer=1 are visible the cycle after that sample (latency 1).
- State OVERHEAT (cpu_overheated=1, shut_off_computer=1):
  - Valid cool sample: cool_cnt+1.
  - Any other valid sample: cool_cnt cleared.
  - When cool_cnt reaches DEBOUNCE: next state COOLDOWN, cool_cnt cleared, timer loaded with COOLDOWN_CYC.
  - cpu_overheated=0 the following cycle; shut_off_computer stays 1.
- State COOLDOWN (cpu_overheated=0, shut_off_computer=1):
  - timer decrements every clk.
  - On the edge where timer==1 and no hot sample: next state NORMAL, shut_off_computer=0. Shut-off is therefore held exactly COOLDOWN_CYC cycles after leaving OVERHEAT.
  - Any single valid hot sample in COOLDOWN (no debounce): next state OVERHEAT, timer cleared, trip_count+1.
  - Simultaneous hot sample and timer expiry: re-trip wins, state OVERHEAT.
- Samples in the band COOL_THRESH..HOT_THRESH-1 are neither hot nor cool. In NORMAL and OVERHEAT they clear the running count.
- trip_count at 255 stays 255.
- No X or latch on any output in any state. Illegal state encodings recover to NORMAL with outputs 0.

Optional Feature:
- Macro THERMAL_GUARD_STICKY_EN.
- Defined:
  - OVERHEAT never exits on cool samples; cpu_overheated and shut_off_computer stay 1 until reset.
  - The COOLDOWN state and timer are not built.
- Undefined: full hysteresis/cooldown behaviour as above.

Test Plan:
- Reset release, no samples for 20 cycles -> cpu_overheated=0, shut_off_computer=0, trip_count=0 throughout.
- Valid samples 95,95,95 on consecutive cycles -> both outputs 1 on the cycle after the third sample; trip_count=1.
- Samples 95,95,80,95,95 -> no trip (band value resets the count). A further 95 -> trip.
- In OVERHEAT, samples 60,60,60 -> cpu_overheated=0 next cycle; shut_off_computer high exactly 16 more cycles, then 0; state NORMAL.
- In COOLDOWN, at timer==5 inject one sample 92 -> cpu_overheated=1 next cycle, trip_count increments. Also drive a hot sample exactly at expiry -> OVERHEAT, not NORMAL.
- Reset pulse while in OVERHEAT and in COOLDOWN -> all outputs 0 on the following edge. 256+ trips -> trip_count holds 255. With THERMAL_GUARD_STICKY_EN, cool samples after a trip -> outputs remain 1.

Source files
------------

// File: rtl/thermal_guard.sv
// thermal_guard: debounced over-temperature detector with hysteresis and cooldown hold.
// Build option THERMAL_GUARD_STICKY_EN latches OVERHEAT until reset (no cooldown path).
module thermal_guard #(
    parameter int TEMP_W       = 8,
    parameter int HOT_THRESH   = 90,
    parameter int COOL_THRESH  = 70,
    parameter int DEBOUNCE     = 3,
    parameter int COOLDOWN_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_data,
    output logic              cpu_overheated,
    output logic              shut_off_computer,
    output logic [7:0]        trip_count
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [TEMP_W-1:0] HOT_T = TEMP_W'(HOT_THRESH);
    localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE - 1);

`ifdef THERMAL_GUARD_STICKY_EN
    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        OVERHEAT = 2'd1
    } state_t;
`else
    localparam int TMR_W = $clog2(COOLDOWN_CYC + 1);
    localparam logic [TEMP_W-1:0] COOL_T = TEMP_W'(COOL_THRESH);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(COOLDOWN_CYC);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        OVERHEAT = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             is_cool;
`endif

    state_t     state_q, state_d;
    logic [CNT_W-1:0] hot_cnt_q, hot_cnt_d;
    logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
    logic [7:0] trip_q, trip_d;
    logic       ovh_q, ovh_d;
    logic       shut_q, shut_d;
    logic       is_hot;
    logic [7:0] trip_inc;

    assign is_hot   = temp_valid && (temp_data >= HOT_T);
    assign trip_inc = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;
`ifndef THERMAL_GUARD_STICKY_EN
    assign is_cool  = temp_valid && (temp_data < COOL_T);
`endif

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        hot_cnt_d  = hot_cnt_q;
        cool_cnt_d = cool_cnt_q;
        trip_d     = trip_q;
`ifndef THERMAL_GUARD_STICKY_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            NORMAL: begin
                cool_cnt_d = '0;
                if (is_hot) begin
                    if (hot_cnt_q == DB_LAST) begin
                        state_d   = OVERHEAT;
                        hot_cnt_d = '0;
                        trip_d    = trip_inc;
                    end else begin
                        hot_cnt_d = hot_cnt_q + 1'b1;
                    end
                end else if (temp_valid) begin
                    hot_cnt_d = '0;
                end
            end
            OVERHEAT: begin
                hot_cnt_d = '0;
`ifndef THERMAL_GUARD_STICKY_EN
                if (is_cool) begin
                    if (cool_cnt_q == DB_LAST) begin
                        state_d    = COOLDOWN;
                        cool_cnt_d = '0;
                        timer_d    = TMR_LOAD;
                    end else begin
                        cool_cnt_d = cool_cnt_q + 1'b1;
                    end
                end else if (temp_valid) begin
                    cool_cnt_d = '0;
                end
`endif
            end
`ifndef THERMAL_GUARD_STICKY_EN
            COOLDOWN: begin
                hot_cnt_d  = '0;
                cool_cnt_d = '0;
                if (is_hot) begin
                    state_d = OVERHEAT;
                    timer_d = '0;
                    trip_d  = trip_inc;
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d = NORMAL;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d    = NORMAL;
                hot_cnt_d  = '0;
                cool_cnt_d = '0;
`ifndef THERMAL_GUARD_STICKY_EN
                timer_d    = '0;
`endif
            end
        endcase
        ovh_d  = (state_d == OVERHEAT);
`ifdef THERMAL_GUARD_STICKY_EN
        shut_d = (state_d == OVERHEAT);
`else
        shut_d = (state_d == OVERHEAT) || (state_d == COOLDOWN);
`endif
    end

    // State, counters and outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NORMAL;
            hot_cnt_q  <= '0;
            cool_cnt_q <= '0;
            trip_q     <= '0;
            ovh_q      <= 1'b0;
            shut_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hot_cnt_q  <= hot_cnt_d;
            cool_cnt_q <= cool_cnt_d;
            trip_q     <= trip_d;
            ovh_q      <= ovh_d;
            shut_q     <= shut_d;
        end
    end

`ifndef THERMAL_GUARD_STICKY_EN
    // Cooldown hold timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    assign cpu_overheated    = ovh_q;
    assign shut_off_computer = shut_q;
    assign trip_count        = trip_q;

endmodule

// File: tb/tb_thermal_guard.sv
// tb_thermal_guard: directed self-checking bench for thermal_guard.
// Expected values are hand-derived for DEBOUNCE=3, COOLDOWN_CYC=16.
module tb_thermal_guard;

    logic       clk = 1'b0;
    logic       reset;
    logic       temp_valid;
    logic [7:0] temp_data;
    logic       cpu_overheated;
    logic       shut_off_computer;
    logic [7:0] trip_count;

    int checks = 0;
    int errors = 0;

    thermal_guard dut (
        .clk               (clk),
        .reset             (reset),
        .temp_valid        (temp_valid),
        .temp_data         (temp_data),
        .cpu_overheated    (cpu_overheated),
        .shut_off_computer (shut_off_computer),
        .trip_count        (trip_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of input, then look 1ns past the edge that used it.
    task automatic tick(input logic v, input logic [7:0] d);
        temp_valid = v;
        temp_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic o, input logic s,
                        input logic [7:0] t);
        chk({tag, ".ovh"}, {7'd0, cpu_overheated}, {7'd0, o});
        chk({tag, ".shut"}, {7'd0, shut_off_computer}, {7'd0, s});
        chk({tag, ".trip"}, trip_count, t);
    endtask

    initial begin
        reset      = 1'b1;
        temp_valid = 1'b0;
        temp_data  = '0;
        @(posedge clk);
        #1;
        tick(0, 0);
        chk3("reset", 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 0);
            chk3("idle", 0, 0, 0);
        end

        tick(1, 95);
        tick(1, 95);
        chk3("hot2", 0, 0, 0);
        tick(1, 95);
        chk3("trip1", 1, 1, 1);

`ifdef THERMAL_GUARD_STICKY_EN
        for (int i = 0; i < 6; i++) tick(1, 60);
        for (int i = 0; i < 20; i++) tick(0, 0);
        chk3("sticky", 1, 1, 1);
        reset = 1'b1;
        tick(0, 0);
        reset = 1'b0;
        chk3("sticky_rst", 0, 0, 0);
`else
        tick(1, 60);
        tick(1, 60);
        tick(1, 80);
        tick(1, 60);
        tick(1, 60);
        chk3("cool_band", 1, 1, 1);
        tick(1, 60);
        chk3("cool_enter", 0, 1, 1);
        for (int i = 0; i < 15; i++) begin
            tick(0, 0);
            chk3("hold", 0, 1, 1);
        end
        tick(0, 0);
        chk3("hold_end", 0, 0, 1);

        tick(1, 95);
        tick(1, 95);
        tick(1, 80);
        tick(1, 95);
        tick(1, 95);
        chk3("band_norm", 0, 0, 1);
        tick(1, 95);
        chk3("trip2", 1, 1, 2);

        for (int i = 0; i < 3; i++) tick(1, 60);
        for (int i = 0; i < 11; i++) tick(0, 0);
        chk3("cd_t5", 0, 1, 2);
        tick(1, 92);
        chk3("retrip_mid", 1, 1, 3);

        for (int i = 0; i < 3; i++) tick(1, 60);
        for (int i = 0; i < 15; i++) tick(0, 0);
        chk3("cd_t1", 0, 1, 3);
        tick(1, 95);
        chk3("retrip_exp", 1, 1, 4);

        reset = 1'b1;
        tick(1, 95);
        reset = 1'b0;
        chk3("rst_ovh", 0, 0, 0);

        tick(1, 95);
        tick(0, 0);
        tick(1, 95);
        tick(0, 0);
        chk3("gap", 0, 0, 0);
        tick(1, 95);
        chk3("gap_trip", 1, 1, 1);
        for (int i = 0; i < 3; i++) tick(1, 60);
        tick(0, 0);
        tick(0, 0);
        chk3("in_cd", 0, 1, 1);
        reset = 1'b1;
        tick(1, 60);
        reset = 1'b0;
        chk3("rst_cd", 0, 0, 0);

        for (int i = 0; i < 3; i++) tick(1, 95);
        for (int i = 0; i < 259; i++) begin
            tick(1, 60);
            tick(1, 60);
            tick(1, 60);
            tick(1, 95);
            if (i == 252) chk("trip254", trip_count, 254);
            if (i == 253) chk("trip255", trip_count, 255);
        end
        chk3("sat", 1, 1, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
